keypad_entry_unit: RTL and testbench
====================================

// Module: keypad_entry_unit
// PURPOSE
//  Parametrised user-input front end between keypad_decoder/switches and data_mem/hazard_unit.
//  Assembles multi-digit decimal numbers from debounced key codes, with press-edge detection,
//  digit limit, overflow rejection, sign entry and clear. Also provides switch-input mode and
//  CPU pause/resume (resume gated by UART completion).
// PARAMETERS
//  DATA_WIDTH  32  width of input_data and internal magnitude register
//  SWITCH_CNT  24  number of toggle switches (<= DATA_WIDTH)
//  MAX_DIGITS  10  max decimal digits accepted per entry (1..15)
//  SIGNED_EN    1  1: key D toggles sign, output is two's complement; 0: key D ignored
// PORTS
//  clk             in   1           system clock, all state on posedge
//  rst_n           in   1           asynchronous active-low reset
//  key_coord       in   8           {row,col} key code from keypad_decoder, 8'h00 = no key
//  switch_map      in   SWITCH_CNT  raw toggle switches
//  uart_complete   in   1           UART upload done (upg_done_i), enables resume
//  input_enable    in   1           data_mem requests a user value
//  input_complete  out  1           entry confirmed (ENTER/PAUSE), to hazard_unit
//  input_data      out  DATA_WIDTH  value to data_mem
//  switch_enable   out  1           switch mode active, to seven_seg_unit/output_unit
//  cpu_pause       out  1           CPU halted by user
//  digit_count     out  4           digits currently held in keypad entry
//  overflow        out  1           last digit rejected (limit or range)
//  negative        out  1           sign flag of keypad entry
// BEHAVIOUR
//  Reset: all outputs 0, state BLOCK, magnitude 0, key_prev 0.
//  Key codes: 0-9 as keypad_decoder map; *=BACKSPACE 7E, #=ENTER 7B, A=PAUSE E7,
//   B=TOGGLE D7, C=CLEAR B7, D=SIGN 77. Unknown nonzero codes: no effect.
//  Press event: key_coord!=0 && key_prev==0 (key_prev = key_coord registered each cycle).
//   A held key acts exactly once; effect visible one cycle after the first nonzero sample.
//  input_data = switch_enable ? zero-extended switch_map : (negative ? -mag : mag), combinational.
//  States: BLOCK, SWITCH, KEYPAD, HALT.
//  BLOCK: PAUSE press -> HALT, cpu_pause=1 (priority over input_enable).
//   else input_enable=1 -> clear mag/digit_count/overflow/negative, input_complete=0;
//   go SWITCH if switch_enable=1, else KEYPAD (switch mode persists across entries).
//  SWITCH/KEYPAD, input_enable=0: -> BLOCK, input_complete unchanged (abandoned entry).
//  SWITCH: TOGGLE -> KEYPAD, switch_enable=0; ENTER -> BLOCK, input_complete=1;
//   PAUSE -> HALT, input_complete=1, cpu_pause=1. Digits/other keys ignored.
//  KEYPAD: TOGGLE -> SWITCH, switch_enable=1 (entry kept); ENTER/PAUSE as SWITCH;
//   digit d: if digit_count==MAX_DIGITS or mag*10+d > 2^(DATA_WIDTH-1)-1 (SIGNED_EN=1)
//   / 2^DATA_WIDTH-1 (SIGNED_EN=0): reject, overflow=1, mag unchanged;
//   else mag=mag*10+d, digit_count+1, overflow=0. Leading zeros count as digits.
//   BACKSPACE: if digit_count>0: mag=mag/10, digit_count-1; overflow=0 always.
//   CLEAR: mag=0, digit_count=0, negative=0, overflow=0. SIGN: negative toggles.
//  ENTER/PAUSE clear digit_count; mag and negative hold so input_data stays valid after.
//  HALT: PAUSE press with uart_complete=1 -> BLOCK, cpu_pause=0; otherwise stay, cpu_pause=1.
//  Reset asserted mid-entry: immediate return to reset values, no input_complete pulse.
//  Arithmetic: mag*10+d computed at DATA_WIDTH+4 bits before range compare (no wrap).
// TESTING
//  1 input_enable=1, press 1,2,3,# (one cycle each, 0 between) -> input_data=123, input_complete=1.
//  2 Hold key 5 for 20 cycles then # -> input_data=5, digit_count was 1 (single action).
//  3 Enter 2147483647 then 8 (DATA_WIDTH=32, SIGNED_EN=1) -> overflow=1, value unchanged; * -> 214748364.
//  4 Press 4,2,D,# -> negative=1, input_data=32'hFFFF_FFD6; C mid-entry -> input_data=0.
//  5 B, switch_map=24'h0000A5, # -> switch_enable=1, input_data=32'hA5; next entry starts in SWITCH.
//  6 A with uart_complete=0 -> cpu_pause=1, second A ignored; uart_complete=1 then A -> cpu_pause=0, BLOCK.

Source files
------------

// File: rtl/keypad_entry_unit_if.sv
// Value-request handshake between data_mem (master) and the keypad entry unit (slave).
interface keypad_entry_unit_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  input_enable;
  logic                  input_complete;
  logic [DATA_WIDTH-1:0] input_data;

  modport master (output input_enable, input input_complete, input input_data);
  modport slave  (input input_enable, output input_complete, output input_data);
endinterface

// File: rtl/keypad_entry_unit.sv
// User-input front end: assembles signed/unsigned decimal numbers from keypad press
// events, offers a switch-input mode, and lets the user pause/resume the CPU.
module keypad_entry_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int SWITCH_CNT = 24,
  parameter int MAX_DIGITS = 10,
  parameter bit SIGNED_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            key_coord,
  input  logic [SWITCH_CNT-1:0] switch_map,
  input  logic                  uart_complete,
  keypad_entry_unit_if.slave    mem_if,
  output logic                  switch_enable,
  output logic                  cpu_pause,
  output logic [3:0]            digit_count,
  output logic                  overflow,
  output logic                  negative
);

  // {row,col} codes of the non-digit keys.
  localparam logic [7:0] CODE_BACK   = 8'h7E;  // *
  localparam logic [7:0] CODE_ENTER  = 8'h7B;  // #
  localparam logic [7:0] CODE_PAUSE  = 8'hE7;  // A
  localparam logic [7:0] CODE_TOGGLE = 8'hD7;  // B
  localparam logic [7:0] CODE_CLEAR  = 8'hB7;  // C
  localparam logic [7:0] CODE_SIGN   = 8'h77;  // D

  // Extra 4 bits keep mag*10+d from wrapping before the range compare.
  localparam int EXT_W = DATA_WIDTH + 4;
  localparam logic [EXT_W-1:0] MAG_LIMIT = SIGNED_EN ? ((EXT_W'(1) << (DATA_WIDTH - 1)) - EXT_W'(1))
                                                     : ((EXT_W'(1) << DATA_WIDTH) - EXT_W'(1));

  typedef enum logic [1:0] {ST_BLOCK, ST_SWITCH, ST_KEYPAD, ST_HALT} state_e;
  typedef enum logic [2:0] {
    KEY_NONE, KEY_DIGIT, KEY_BACK, KEY_ENTER, KEY_PAUSE, KEY_TOGGLE, KEY_CLEAR, KEY_SIGN
  } key_kind_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mag_q, mag_d;
  logic [3:0]            digit_count_q, digit_count_d;
  logic                  overflow_q, overflow_d;
  logic                  negative_q, negative_d;
  logic                  switch_enable_q, switch_enable_d;
  logic                  cpu_pause_q, cpu_pause_d;
  logic                  input_complete_q, input_complete_d;
  logic [7:0]            key_prev_q, key_prev_d;

  key_kind_e             key_kind;
  logic [3:0]            key_digit;
  logic                  key_press;
  logic [EXT_W-1:0]      mag_ext_next;

  // Classify the current key code; a held key only acts on its first sample.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
    key_kind  = KEY_NONE;
    key_digit = 4'd0;
    unique case (key_coord)
      8'h7D: begin key_kind = KEY_DIGIT; key_digit = 4'd0; end
      8'hEE: begin key_kind = KEY_DIGIT; key_digit = 4'd1; end
      8'hED: begin key_kind = KEY_DIGIT; key_digit = 4'd2; end
      8'hEB: begin key_kind = KEY_DIGIT; key_digit = 4'd3; end
      8'hDE: begin key_kind = KEY_DIGIT; key_digit = 4'd4; end
      8'hDD: begin key_kind = KEY_DIGIT; key_digit = 4'd5; end
      8'hDB: begin key_kind = KEY_DIGIT; key_digit = 4'd6; end
      8'hBE: begin key_kind = KEY_DIGIT; key_digit = 4'd7; end
      8'hBD: begin key_kind = KEY_DIGIT; key_digit = 4'd8; end
      8'hBB: begin key_kind = KEY_DIGIT; key_digit = 4'd9; end
      CODE_BACK:   key_kind = KEY_BACK;
      CODE_ENTER:  key_kind = KEY_ENTER;
      CODE_PAUSE:  key_kind = KEY_PAUSE;
      CODE_TOGGLE: key_kind = KEY_TOGGLE;
      CODE_CLEAR:  key_kind = KEY_CLEAR;
      CODE_SIGN:   key_kind = KEY_SIGN;
      default:     key_kind = KEY_NONE;
    endcase
  end

  assign key_press    = (key_coord != 8'h00) && (key_prev_q == 8'h00);
  assign mag_ext_next = {4'b0000, mag_q} * EXT_W'(10) + EXT_W'(key_digit);

  // Next-state and entry-register update for all four modes.
  always_comb begin
    state_d          = state_q;
    mag_d            = mag_q;
    digit_count_d    = digit_count_q;
    overflow_d       = overflow_q;
    negative_d       = negative_q;
    switch_enable_d  = switch_enable_q;
    cpu_pause_d      = cpu_pause_q;
    input_complete_d = input_complete_q;
    key_prev_d       = key_coord;

    unique case (state_q)
      ST_BLOCK: begin
        if (key_press && key_kind == KEY_PAUSE) begin
          state_d     = ST_HALT;
          cpu_pause_d = 1'b1;
        end else if (mem_if.input_enable) begin
          mag_d            = '0;
          digit_count_d    = 4'd0;
          overflow_d       = 1'b0;
          negative_d       = 1'b0;
          input_complete_d = 1'b0;
          state_d          = switch_enable_q ? ST_SWITCH : ST_KEYPAD;
        end
      end

      ST_SWITCH, ST_KEYPAD: begin
        if (!mem_if.input_enable) begin
          // Entry abandoned by data_mem; completion flag left as it was.
          state_d = ST_BLOCK;
        end else if (key_press) begin
          unique case (key_kind)
            KEY_TOGGLE: begin
              state_d         = (state_q == ST_SWITCH) ? ST_KEYPAD : ST_SWITCH;
              switch_enable_d = (state_q == ST_KEYPAD);
            end
            KEY_ENTER: begin
              state_d          = ST_BLOCK;
              input_complete_d = 1'b1;
              digit_count_d    = 4'd0;
            end
            KEY_PAUSE: begin
              state_d          = ST_HALT;
              input_complete_d = 1'b1;
              cpu_pause_d      = 1'b1;
              digit_count_d    = 4'd0;
            end
            KEY_DIGIT: begin
              if (state_q == ST_KEYPAD) begin
                if (digit_count_q == 4'(MAX_DIGITS) || mag_ext_next > MAG_LIMIT) begin
                  overflow_d = 1'b1;
                end else begin
                  mag_d         = mag_ext_next[DATA_WIDTH-1:0];
                  digit_count_d = digit_count_q + 4'd1;
                  overflow_d    = 1'b0;
                end
              end
            end
            KEY_BACK: begin
              if (state_q == ST_KEYPAD) begin
                if (digit_count_q != 4'd0) begin
                  mag_d         = mag_q / DATA_WIDTH'(10);
                  digit_count_d = digit_count_q - 4'd1;
                end
                overflow_d = 1'b0;
              end
            end
            KEY_CLEAR: begin
              if (state_q == ST_KEYPAD) begin
                mag_d         = '0;
                digit_count_d = 4'd0;
                negative_d    = 1'b0;
                overflow_d    = 1'b0;
              end
            end
            KEY_SIGN: begin
              if (state_q == ST_KEYPAD && SIGNED_EN) negative_d = ~negative_q;
            end
            default: ;
          endcase
        end
      end

      ST_HALT: begin
        if (key_press && key_kind == KEY_PAUSE && uart_complete) begin
          state_d     = ST_BLOCK;
          cpu_pause_d = 1'b0;
        end
      end

      default: state_d = ST_BLOCK;
    endcase
  end

  // State and entry registers; asynchronous reset returns everything to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q          <= ST_BLOCK;
      mag_q            <= '0;
      digit_count_q    <= 4'd0;
      overflow_q       <= 1'b0;
      negative_q       <= 1'b0;
      switch_enable_q  <= 1'b0;
      cpu_pause_q      <= 1'b0;
      input_complete_q <= 1'b0;
      key_prev_q       <= 8'h00;
    end else begin
      state_q          <= state_d;
      mag_q            <= mag_d;
      digit_count_q    <= digit_count_d;
      overflow_q       <= overflow_d;
      negative_q       <= negative_d;
      switch_enable_q  <= switch_enable_d;
      cpu_pause_q      <= cpu_pause_d;
      input_complete_q <= input_complete_d;
      key_prev_q       <= key_prev_d;
    end
  end

  assign mem_if.input_data     = switch_enable_q ? DATA_WIDTH'(switch_map)
                               : (negative_q ? (DATA_WIDTH'(0) - mag_q) : mag_q);
  assign mem_if.input_complete = input_complete_q;
  assign switch_enable         = switch_enable_q;
  assign cpu_pause             = cpu_pause_q;
  assign digit_count           = digit_count_q;
  assign overflow              = overflow_q;
  assign negative              = negative_q;

endmodule

// File: tb/tb_keypad_entry_unit.sv
// Self-checking bench for keypad_entry_unit: directed scenarios plus a randomized
// run compared against a behavioural model of the entry rules.
module tb_keypad_entry_unit;
  localparam int DW = 32;
  localparam int SW = 24;

  localparam logic [7:0] K_BACK   = 8'h7E;
  localparam logic [7:0] K_ENTER  = 8'h7B;
  localparam logic [7:0] K_PAUSE  = 8'hE7;
  localparam logic [7:0] K_TOGGLE = 8'hD7;
  localparam logic [7:0] K_CLEAR  = 8'hB7;
  localparam logic [7:0] K_SIGN   = 8'h77;
  localparam logic [7:0] DIGIT_KEY [10] =
    '{8'h7D, 8'hEE, 8'hED, 8'hEB, 8'hDE, 8'hDD, 8'hDB, 8'hBE, 8'hBD, 8'hBB};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    key_coord;
  logic [SW-1:0] switch_map;
  logic          uart_complete;
  logic          switch_enable, cpu_pause, overflow, negative;
  logic [3:0]    digit_count;

  int checks   = 0;
  int failures = 0;

  // Stimulus levels held between steps.
  bit            cur_en = 1'b0;
  bit            cur_uc = 1'b0;
  logic [SW-1:0] cur_sw = '0;

  // Behavioural model of the user-visible entry state.
  longint unsigned m_mag;
  int              m_digits;
  bit              m_neg, m_ovf, m_sw, m_pause, m_complete, m_entering, m_halted;
  logic [7:0]      m_prev;

  always #5 clk = ~clk;

  keypad_entry_unit_if #(.DATA_WIDTH(DW)) mem_if ();

  keypad_entry_unit #(
    .DATA_WIDTH(DW), .SWITCH_CNT(SW), .MAX_DIGITS(10), .SIGNED_EN(1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_coord     (key_coord),
    .switch_map    (switch_map),
    .uart_complete (uart_complete),
    .mem_if        (mem_if),
    .switch_enable (switch_enable),
    .cpu_pause     (cpu_pause),
    .digit_count   (digit_count),
    .overflow      (overflow),
    .negative      (negative)
  );

  function automatic int digit_of(input logic [7:0] k);
    for (int i = 0; i < 10; i++) if (DIGIT_KEY[i] == k) return i;
    return -1;
  endfunction

  function automatic logic [DW-1:0] model_data();
    logic [DW-1:0] m;
    m = DW'(m_mag);
    if (m_sw) return DW'(cur_sw);
    return m_neg ? (DW'(0) - m) : m;
  endfunction

  task automatic model_reset();
    m_mag = 0; m_digits = 0; m_neg = 0; m_ovf = 0; m_sw = 0; m_pause = 0;
    m_complete = 0; m_entering = 0; m_halted = 0; m_prev = 8'h00;
  endtask

  // One clock of the entry rules, expressed in terms of the user-level flags.
  task automatic model_clock(input logic [7:0] k, input bit en, input bit uc);
    bit pressed;
    int d;
    longint unsigned v;
    pressed = (k != 8'h00) && (m_prev == 8'h00);
    m_prev  = k;
    if (m_halted) begin
      if (pressed && k == K_PAUSE && uc) begin m_halted = 0; m_pause = 0; end
    end else if (!m_entering) begin
      if (pressed && k == K_PAUSE) begin m_halted = 1; m_pause = 1; end
      else if (en) begin
        m_entering = 1; m_mag = 0; m_digits = 0; m_ovf = 0; m_neg = 0; m_complete = 0;
      end
    end else if (!en) begin
      m_entering = 0;
    end else if (pressed) begin
      d = digit_of(k);
      if (k == K_TOGGLE) m_sw = !m_sw;
      else if (k == K_ENTER || k == K_PAUSE) begin
        m_entering = 0; m_complete = 1; m_digits = 0;
        if (k == K_PAUSE) begin m_halted = 1; m_pause = 1; end
      end else if (!m_sw) begin
        if (d >= 0) begin
          v = m_mag * 10 + longint'(d);
          if (m_digits == 10 || v > 64'h7FFF_FFFF) m_ovf = 1;
          else begin m_mag = v; m_digits++; m_ovf = 0; end
        end else if (k == K_BACK) begin
          if (m_digits > 0) begin m_mag = m_mag / 10; m_digits--; end
          m_ovf = 0;
        end else if (k == K_CLEAR) begin
          m_mag = 0; m_digits = 0; m_neg = 0; m_ovf = 0;
        end else if (k == K_SIGN) m_neg = !m_neg;
      end
    end
  endtask

  // Drive one cycle from a negedge; returns at the next negedge for sampling.
  task automatic step(input logic [7:0] k);
    key_coord           = k;
    mem_if.input_enable = cur_en;
    uart_complete       = cur_uc;
    switch_map          = cur_sw;
    @(posedge clk);
    model_clock(k, cur_en, cur_uc);
    @(negedge clk);
  endtask

  task automatic press(input logic [7:0] k);
    step(k);
    step(8'h00);
  endtask

  task automatic type_number(input string s);
    for (int i = 0; i < s.len(); i++) press(DIGIT_KEY[int'(s[i]) - 48]);
  endtask

  task automatic begin_entry();
    cur_en = 1'b1;
    step(8'h00);
  endtask

  // ENTER, with data_mem dropping input_enable once the entry is confirmed.
  task automatic finish_entry();
    step(K_ENTER);
    cur_en = 1'b0;
    step(8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_coord = 8'h00; mem_if.input_enable = 1'b0; uart_complete = 1'b0; switch_map = '0;
    cur_en = 0; cur_uc = 0; cur_sw = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_if.input_complete, switch_enable, cpu_pause, overflow, negative, digit_count} !== 9'd0
        || mem_if.input_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b/%h exp=0/0",
               {mem_if.input_complete, switch_enable, cpu_pause, overflow, negative, digit_count},
               mem_if.input_data);
    end
  endtask

  task automatic test_decimal();
    begin_entry();
    type_number("123");
    finish_entry();
    checks++;
    if (mem_if.input_data !== 32'd123) begin
      failures++; $display("FAIL dec_data got=%0d exp=123", mem_if.input_data);
    end
    checks++;
    if (mem_if.input_complete !== 1'b1 || digit_count !== 4'd0) begin
      failures++;
      $display("FAIL dec_complete got=%b/%0d exp=1/0", mem_if.input_complete, digit_count);
    end
  endtask

  task automatic test_hold();
    begin_entry();
    checks++;
    if (mem_if.input_complete !== 1'b0) begin
      failures++; $display("FAIL hold_start_complete got=%b exp=0", mem_if.input_complete);
    end
    repeat (20) step(DIGIT_KEY[5]);
    checks++;
    if (digit_count !== 4'd1 || mem_if.input_data !== 32'd5) begin
      failures++; $display("FAIL hold_single got=%0d/%0d exp=1/5", digit_count, mem_if.input_data);
    end
    step(8'h00);
    finish_entry();
    checks++;
    if (mem_if.input_data !== 32'd5 || mem_if.input_complete !== 1'b1) begin
      failures++;
      $display("FAIL hold_enter got=%0d/%b exp=5/1", mem_if.input_data, mem_if.input_complete);
    end
  endtask

  task automatic test_overflow();
    begin_entry();
    type_number("2147483647");
    checks++;
    if (mem_if.input_data !== 32'd2147483647 || digit_count !== 4'd10) begin
      failures++;
      $display("FAIL ovf_max got=%0d/%0d exp=2147483647/10", mem_if.input_data, digit_count);
    end
    press(DIGIT_KEY[8]);
    checks++;
    if (overflow !== 1'b1 || mem_if.input_data !== 32'd2147483647) begin
      failures++; $display("FAIL ovf_limit got=%b/%0d exp=1/2147483647", overflow, mem_if.input_data);
    end
    press(K_BACK);
    checks++;
    if (overflow !== 1'b0 || mem_if.input_data !== 32'd214748364 || digit_count !== 4'd9) begin
      failures++;
      $display("FAIL ovf_back got=%b/%0d/%0d exp=0/214748364/9", overflow, mem_if.input_data, digit_count);
    end
    press(DIGIT_KEY[8]);
    checks++;
    if (overflow !== 1'b1 || mem_if.input_data !== 32'd214748364) begin
      failures++; $display("FAIL ovf_range got=%b/%0d exp=1/214748364", overflow, mem_if.input_data);
    end
    press(DIGIT_KEY[7]);
    checks++;
    if (overflow !== 1'b0 || mem_if.input_data !== 32'd2147483647) begin
      failures++; $display("FAIL ovf_edge got=%b/%0d exp=0/2147483647", overflow, mem_if.input_data);
    end
    finish_entry();
    begin_entry();
    type_number("0000000000");
    press(DIGIT_KEY[1]);
    checks++;
    if (overflow !== 1'b1 || digit_count !== 4'd10 || mem_if.input_data !== 32'd0) begin
      failures++;
      $display("FAIL ovf_digits got=%b/%0d/%0d exp=1/10/0", overflow, digit_count, mem_if.input_data);
    end
    finish_entry();
  endtask

  task automatic test_sign_clear();
    begin_entry();
    checks++;
    if (overflow !== 1'b0) begin
      failures++; $display("FAIL sign_ovf_cleared got=%b exp=0", overflow);
    end
    type_number("42");
    press(K_SIGN);
    finish_entry();
    checks++;
    if (negative !== 1'b1 || mem_if.input_data !== 32'hFFFF_FFD6) begin
      failures++; $display("FAIL sign_neg got=%b/%h exp=1/ffffffd6", negative, mem_if.input_data);
    end
    begin_entry();
    type_number("7");
    press(K_SIGN);
    press(K_CLEAR);
    checks++;
    if (mem_if.input_data !== 32'd0 || digit_count !== 4'd0 || negative !== 1'b0) begin
      failures++;
      $display("FAIL clear got=%h/%0d/%b exp=0/0/0", mem_if.input_data, digit_count, negative);
    end
    finish_entry();
  endtask

  task automatic test_switch();
    begin_entry();
    cur_sw = 24'h0000A5;
    press(K_TOGGLE);
    press(DIGIT_KEY[3]);
    checks++;
    if (switch_enable !== 1'b1 || mem_if.input_data !== 32'h0000_00A5 || digit_count !== 4'd0) begin
      failures++;
      $display("FAIL sw_mode got=%b/%h/%0d exp=1/a5/0", switch_enable, mem_if.input_data, digit_count);
    end
    finish_entry();
    checks++;
    if (mem_if.input_complete !== 1'b1 || mem_if.input_data !== 32'h0000_00A5) begin
      failures++;
      $display("FAIL sw_enter got=%b/%h exp=1/a5", mem_if.input_complete, mem_if.input_data);
    end
    begin_entry();
    checks++;
    if (switch_enable !== 1'b1 || mem_if.input_complete !== 1'b0) begin
      failures++;
      $display("FAIL sw_persist got=%b/%b exp=1/0", switch_enable, mem_if.input_complete);
    end
    press(K_TOGGLE);
    press(DIGIT_KEY[3]);
    checks++;
    if (switch_enable !== 1'b0 || mem_if.input_data !== 32'd3 || digit_count !== 4'd1) begin
      failures++;
      $display("FAIL sw_back got=%b/%0d/%0d exp=0/3/1", switch_enable, mem_if.input_data, digit_count);
    end
    finish_entry();
  endtask

  task automatic test_pause();
    cur_en = 1'b0; cur_uc = 1'b0;
    press(K_PAUSE);
    press(K_PAUSE);
    checks++;
    if (cpu_pause !== 1'b1) begin
      failures++; $display("FAIL pause_hold got=%b exp=1", cpu_pause);
    end
    cur_uc = 1'b1;
    press(K_PAUSE);
    checks++;
    if (cpu_pause !== 1'b0) begin
      failures++; $display("FAIL pause_resume got=%b exp=0", cpu_pause);
    end
    cur_uc = 1'b0;
    begin_entry();
    type_number("1");
    press(K_PAUSE);
    checks++;
    if (cpu_pause !== 1'b1 || mem_if.input_complete !== 1'b1 || mem_if.input_data !== 32'd1
        || digit_count !== 4'd0) begin
      failures++;
      $display("FAIL pause_entry got=%b/%b/%0d/%0d exp=1/1/1/0",
               cpu_pause, mem_if.input_complete, mem_if.input_data, digit_count);
    end
    cur_en = 1'b0; cur_uc = 1'b1;
    press(K_PAUSE);
    cur_uc = 1'b0;
    checks++;
    if (cpu_pause !== 1'b0) begin
      failures++; $display("FAIL pause_exit got=%b exp=0", cpu_pause);
    end
  endtask

  task automatic test_abandon();
    begin_entry();
    type_number("9");
    cur_en = 1'b0;
    step(8'h00);
    press(DIGIT_KEY[5]);
    checks++;
    if (mem_if.input_complete !== 1'b0 || digit_count !== 4'd1 || mem_if.input_data !== 32'd9) begin
      failures++;
      $display("FAIL abandon got=%b/%0d/%0d exp=0/1/9", mem_if.input_complete, digit_count, mem_if.input_data);
    end
  endtask

  task automatic test_reset_mid();
    begin_entry();
    type_number("6");
    press(K_SIGN);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_if.input_data !== 32'd0 || negative !== 1'b0 || digit_count !== 4'd0
        || mem_if.input_complete !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got=%h/%b/%0d/%b exp=0/0/0/0",
               mem_if.input_data, negative, digit_count, mem_if.input_complete);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cur_en = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    logic [7:0] pool [17];
    logic [7:0] k;
    logic [40:0] got, exp;
    for (int i = 0; i < 10; i++) pool[i] = DIGIT_KEY[i];
    pool[10] = K_BACK;  pool[11] = K_ENTER; pool[12] = K_PAUSE; pool[13] = K_TOGGLE;
    pool[14] = K_CLEAR; pool[15] = K_SIGN;  pool[16] = 8'h12;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      k      = ($urandom_range(0, 9) < 4) ? 8'h00 : pool[$urandom_range(0, 16)];
      cur_en = ($urandom_range(0, 24) != 0);
      cur_uc = $urandom_range(0, 1);
      cur_sw = SW'($urandom);
      step(k);
      got = {mem_if.input_complete, switch_enable, cpu_pause, overflow, negative, digit_count,
             mem_if.input_data};
      exp = {m_complete, m_sw, m_pause, m_ovf, m_neg, 4'(m_digits), model_data()};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL rand_cycle%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_hold();
    test_overflow();
    test_sign_clear();
    test_switch();
    test_pause();
    test_abandon();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
